// File: rtl/memory_cycle.sv
// memory_cycle: memory stage of a pipelined core. It issues one data-memory
// access per load/store, stalls the pipeline while the memory is not ready,
// aborts an access that waits too long, and registers the result towards
// the writeback stage.
//
// Parameter
//   WAIT_MAX     maximum WAIT cycles before an access is aborted (1..255)
// Optional feature
//   MISALIGN_CHECK_EN  when defined, a misaligned half/word access is not
//                      issued and retires at once with ExcW=1
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   RegWriteM..InstrM              instruction in the M register
//   dmem_req/we/addr/wdata/be      data-memory request (combinational)
//   dmem_ready, dmem_rdata         data-memory response
//   StallM                         freeze upstream stages and M register
//   RegWriteW..InstrW, ReadDataW,
//   ExcW                           registered writeback-stage values
module memory_cycle #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        LoadM,
    input  logic        StoreM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] InstrM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] InstrW,
    output logic [31:0] ReadDataW,
    output logic        ExcW
);

    // Counter value seen in the last WAIT cycle before the access aborts.
    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state;
    logic [7:0]  waitCnt;

    logic [2:0]  funct3;
    logic        access;
    logic        isLoad;
    logic        isByte;
    logic        isHalf;
    logic        misalign;
    logic        issue;
    logic        abort;
    logic        stall;
    logic        complete;
    logic        fault;
    logic [7:0]  byteLane;
    logic [15:0] halfLane;
    logic [31:0] loadData;

    // Access decode, abort and stall conditions.
    always_comb begin
        funct3 = InstrM[14:12];
        access = LoadM | StoreM;
        isLoad = LoadM & ~StoreM;
        // Unsigned byte/half encodings exist only for loads; anything
        // else that is not byte or half is a word access.
        isByte = (funct3 == 3'b000) | (isLoad & (funct3 == 3'b100));
        isHalf = (funct3 == 3'b001) | (isLoad & (funct3 == 3'b101));
`ifdef MISALIGN_CHECK_EN
        misalign = access & ((isHalf & ALU_ResultM[0]) |
                   (~isByte & ~isHalf & (ALU_ResultM[1:0] != 2'b00)));
`else
        misalign = 1'b0;
`endif
        issue    = access & ~misalign & ~rst;
        // Ready in the limit cycle wins over the abort.
        abort    = issue & (state == WAIT) & ~dmem_ready &
                   (waitCnt >= WAIT_LIMIT);
        stall    = issue & ~dmem_ready & ~abort;
        complete = issue & dmem_ready;
        fault    = abort | misalign;
    end

    // Request side: address, lane-replicated data and byte enables.
    // Loads fetch the whole word, so their enables carry only the size.
    always_comb begin
        dmem_req   = issue;
        dmem_we    = StoreM;
        dmem_addr  = {ALU_ResultM[31:2], 2'b00};
        dmem_wdata = WriteDataM;
        dmem_be    = 4'b1111;
        if (isByte) begin
            dmem_wdata = {4{WriteDataM[7:0]}};
            dmem_be    = StoreM ? (4'b0001 << ALU_ResultM[1:0]) : 4'b0001;
        end else if (isHalf) begin
            dmem_wdata = {2{WriteDataM[15:0]}};
            dmem_be    = StoreM ? (4'b0011 << {ALU_ResultM[1], 1'b0})
                                : 4'b0011;
        end
        StallM = stall;
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        case (ALU_ResultM[1:0])
            2'd0:    byteLane = dmem_rdata[7:0];
            2'd1:    byteLane = dmem_rdata[15:8];
            2'd2:    byteLane = dmem_rdata[23:16];
            default: byteLane = dmem_rdata[31:24];
        endcase
        halfLane = ALU_ResultM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        if (isByte) begin
            loadData = funct3[2] ? {24'b0, byteLane}
                                 : {{24{byteLane[7]}}, byteLane};
        end else if (isHalf) begin
            loadData = funct3[2] ? {16'b0, halfLane}
                                 : {{16{halfLane[15]}}, halfLane};
        end else begin
            loadData = dmem_rdata;
        end
    end

    // Wait FSM, timeout counter and the W register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            waitCnt     <= 8'd0;
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 2'b0;
            RD_W        <= 5'b0;
            PCPlus4W    <= 32'b0;
            ALU_ResultW <= 32'b0;
            InstrW      <= 32'b0;
            ReadDataW   <= 32'b0;
            ExcW        <= 1'b0;
        end else if (stall) begin
            // Counter starts at 0 on entry to WAIT; W gets a bubble.
            state     <= WAIT;
            waitCnt   <= (state == WAIT) ? waitCnt + 8'd1 : 8'd0;
            RegWriteW <= 1'b0;
            ExcW      <= 1'b0;
        end else begin
            state       <= IDLE;
            waitCnt     <= 8'd0;
            RegWriteW   <= RegWriteM & ~fault;
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            InstrW      <= InstrM;
            ReadDataW   <= (isLoad & complete) ? loadData : 32'b0;
            ExcW        <= fault;
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
module tb_memory_cycle;

    localparam int WM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        LoadM;
    logic        StoreM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M;
    logic [31:0] WriteDataM;
    logic [31:0] ALU_ResultM;
    logic [31:0] InstrM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        StallM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W;
    logic [31:0] ALU_ResultW;
    logic [31:0] InstrW;
    logic [31:0] ReadDataW;
    logic        ExcW;

    memory_cycle #(.WAIT_MAX(WM)) dut (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .LoadM(LoadM), .StoreM(StoreM), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM), .InstrM(InstrM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .StallM(StallM), .RegWriteW(RegWriteW),
        .ResultSrcW(ResultSrcW), .RD_W(RD_W), .PCPlus4W(PCPlus4W),
        .ALU_ResultW(ALU_ResultW), .InstrW(InstrW), .ReadDataW(ReadDataW),
        .ExcW(ExcW)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: cycles the current access has been held,
    // and the expected W register contents.
    int          waited = 0;
    bit          mStall = 0;
    bit          mRw = 0;
    logic [1:0]  mRs = '0;
    logic [4:0]  mRd = '0;
    logic [31:0] mPc = '0;
    logic [31:0] mAlu = '0;
    logic [31:0] mInstr = '0;
    logic [31:0] mRead = '0;
    bit          mExc = 0;

    // Combinational outputs sampled in the last cycle.
    logic        sReq;
    logic        sStall;
    logic [3:0]  sBe;
    logic [31:0] sWd;
    logic [31:0] sAddr;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int sizeOf(input logic ld, input logic st,
                                  input logic [2:0] f3);
        bit loadOnly = ld && !st;
        if (f3 == 3'd0 || (loadOnly && f3 == 3'd4)) return 1;
        if (f3 == 3'd1 || (loadOnly && f3 == 3'd5)) return 2;
        return 4;
    endfunction

    // One clock cycle: check request side against the model mid-cycle,
    // advance the model, then check the W register after the edge.
    task automatic tick();
        logic [31:0] a, eBe, eWd, v;
        logic [2:0]  f3;
        int          sz;
        bit          acc, mis, iss, tmo, ld;
        @(negedge clk);
        a   = ALU_ResultM;
        f3  = InstrM[14:12];
        acc = LoadM || StoreM;
        ld  = LoadM && !StoreM;
        sz  = sizeOf(LoadM, StoreM, f3);
        mis = 0;
`ifdef MISALIGN_CHECK_EN
        if (acc && ((sz == 2 && a % 2 != 0) || (sz == 4 && a % 4 != 0)))
            mis = 1;
`endif
        iss    = !rst && acc && !mis;
        tmo    = iss && !dmem_ready && (waited == WM);
        mStall = iss && !dmem_ready && !tmo;
        sReq = dmem_req; sStall = StallM; sBe = dmem_be;
        sWd = dmem_wdata; sAddr = dmem_addr;
        chk("dmem_req", 32'(dmem_req), 32'(iss));
        chk("StallM", 32'(StallM), 32'(mStall));
        if (iss) begin
            if (sz == 1) begin
                eBe = StoreM ? (32'd1 << (a % 4)) : 32'd1;
                eWd = 32'(WriteDataM[7:0]) * 32'h0101_0101;
            end else if (sz == 2) begin
                eBe = StoreM ? (32'd3 << (2 * ((a / 2) % 2))) : 32'd3;
                eWd = 32'(WriteDataM[15:0]) * 32'h0001_0001;
            end else begin
                eBe = 32'd15;
                eWd = WriteDataM;
            end
            chk("dmem_we", 32'(dmem_we), 32'(StoreM));
            chk("dmem_addr", dmem_addr, a - (a % 4));
            chk("dmem_be", 32'(dmem_be), eBe);
            if (StoreM) chk("dmem_wdata", dmem_wdata, eWd);
        end
        if (sz == 1) begin
            v = (dmem_rdata >> (8 * (a % 4))) & 32'hFF;
            if (f3 != 3'd4 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = ((a / 2) % 2 == 1) ? (dmem_rdata >> 16) : (dmem_rdata & 32'hFFFF);
            if (f3 != 3'd5 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = dmem_rdata;
        end
        if (rst) begin
            mRw = 0; mRs = '0; mRd = '0; mPc = '0; mAlu = '0; mInstr = '0;
            mRead = '0; mExc = 0; waited = 0;
        end else if (mStall) begin
            mRw = 0; mExc = 0; waited++;
        end else begin
            mExc   = tmo || (acc && mis);
            mRw    = RegWriteM && !mExc;
            mRs    = ResultSrcM; mRd = RD_M; mPc = PCPlus4M;
            mAlu   = ALU_ResultM; mInstr = InstrM;
            mRead  = (ld && iss && dmem_ready) ? v : 32'd0;
            waited = 0;
        end
        @(posedge clk);
        #1;
        chk("RegWriteW", 32'(RegWriteW), 32'(mRw));
        chk("ResultSrcW", 32'(ResultSrcW), 32'(mRs));
        chk("RD_W", 32'(RD_W), 32'(mRd));
        chk("PCPlus4W", PCPlus4W, mPc);
        chk("ALU_ResultW", ALU_ResultW, mAlu);
        chk("InstrW", InstrW, mInstr);
        chk("ReadDataW", ReadDataW, mRead);
        chk("ExcW", 32'(ExcW), 32'(mExc));
    endtask

    task automatic setOp(input bit ld, input bit st, input logic [2:0] f3,
                         input bit rw, input logic [31:0] a,
                         input logic [31:0] wd);
        LoadM = ld; StoreM = st; RegWriteM = rw; ALU_ResultM = a;
        WriteDataM = wd; InstrM = 32'h0000_0003 | (32'(f3) << 12);
        ResultSrcM = 2'd1; RD_M = 5'd7; PCPlus4M = a + 32'h1000;
    endtask

    // LW that never gets ready: must abort after WM WAIT cycles.
    task automatic runHang(input string tag);
        int nReq = 0;
        int nStall = 0;
        bit done = 0;
        setOp(1, 0, 3'd2, 1, 32'h400, 32'h0);
        dmem_ready = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            nReq += int'(sReq);
            nStall += int'(sStall);
            if (!sStall) done = 1;
        end
        chk({tag, "_aborted"}, 32'(done), 32'd1);
        chk({tag, "_stall_cycles"}, 32'(nStall), 32'(WM));
        chk({tag, "_req_cycles"}, 32'(nReq), 32'(WM + 1));
        chk({tag, "_ExcW"}, 32'(ExcW), 32'd1);
        chk({tag, "_RegWriteW"}, 32'(RegWriteW), 32'd0);
        setOp(0, 0, 3'd0, 1, 32'h0, 32'h0);
        tick();
        chk({tag, "_req_dropped"}, 32'(sReq), 32'd0);
    endtask

    typedef struct {
        logic [2:0]  f3;
        bit          ld, st, rw;
        logic [31:0] a, wd, rd;
        bit          eReq;
        logic [3:0]  eBe;
        logic [31:0] eWd, eRd;
        bit          eRw;
    } vec_t;

    vec_t tbl[13];
    bit   hang;
    int   kind;

    initial begin
        tbl[0]  = '{3'd0, 1, 0, 1, 32'h103, 32'h0, 32'h80FF_0000, 1, 4'b0001, 32'h0, 32'hFFFF_FF80, 1};
        tbl[1]  = '{3'd4, 1, 0, 1, 32'h103, 32'h0, 32'h80FF_0000, 1, 4'b0001, 32'h0, 32'h0000_0080, 1};
        tbl[2]  = '{3'd0, 1, 0, 1, 32'h101, 32'h0, 32'h0000_7F00, 1, 4'b0001, 32'h0, 32'h0000_007F, 1};
        tbl[3]  = '{3'd1, 1, 0, 1, 32'h102, 32'h0, 32'h8001_7FFF, 1, 4'b0011, 32'h0, 32'hFFFF_8001, 1};
        tbl[4]  = '{3'd5, 1, 0, 1, 32'h100, 32'h0, 32'h8001_F00D, 1, 4'b0011, 32'h0, 32'h0000_F00D, 1};
        tbl[5]  = '{3'd1, 1, 0, 1, 32'h100, 32'h0, 32'h0000_F00D, 1, 4'b0011, 32'h0, 32'hFFFF_F00D, 1};
        tbl[6]  = '{3'd2, 1, 0, 1, 32'h204, 32'h0, 32'hDEAD_BEEF, 1, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1};
        tbl[7]  = '{3'd3, 1, 0, 1, 32'h10C, 32'h0, 32'h1122_3344, 1, 4'b1111, 32'h0, 32'h1122_3344, 1};
        tbl[8]  = '{3'd0, 0, 1, 0, 32'h101, 32'h1234_56AB, 32'hFFFF_FFFF, 1, 4'b0010, 32'hABAB_ABAB, 32'h0, 0};
        tbl[9]  = '{3'd0, 0, 1, 1, 32'h103, 32'h1234_56AB, 32'hFFFF_FFFF, 1, 4'b1000, 32'hABAB_ABAB, 32'h0, 1};
        tbl[10] = '{3'd1, 0, 1, 0, 32'h200, 32'h1234_ABCD, 32'hFFFF_FFFF, 1, 4'b0011, 32'hABCD_ABCD, 32'h0, 0};
        tbl[11] = '{3'd2, 0, 1, 0, 32'h208, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1, 4'b1111, 32'hCAFE_F00D, 32'h0, 0};
        tbl[12] = '{3'd2, 0, 0, 1, 32'h0,   32'h0, 32'hFFFF_FFFF, 0, 4'b0000, 32'h0, 32'h0, 1};

        // Reset with a pending load on the inputs.
        rst = 1;
        setOp(1, 0, 3'd2, 1, 32'h40, 32'h0);
        dmem_ready = 0;
        dmem_rdata = 32'h0;
        tick();
        chk("rst_req", 32'(sReq), 32'd0);
        chk("rst_stall", 32'(sStall), 32'd0);
        chk("rst_RegWriteW", 32'(RegWriteW), 32'd0);
        chk("rst_PCPlus4W", PCPlus4W, 32'd0);
        tick();
        rst = 0;

        // Single-cycle accesses, ready in the issue cycle.
        for (int i = 0; i < 13; i++) begin
            setOp(tbl[i].ld, tbl[i].st, tbl[i].f3, tbl[i].rw, tbl[i].a, tbl[i].wd);
            dmem_ready = 1;
            dmem_rdata = tbl[i].rd;
            tick();
            chk($sformatf("tbl%0d_req", i), 32'(sReq), 32'(tbl[i].eReq));
            chk($sformatf("tbl%0d_stall", i), 32'(sStall), 32'd0);
            if (tbl[i].eReq) chk($sformatf("tbl%0d_be", i), 32'(sBe), 32'(tbl[i].eBe));
            if (tbl[i].st) chk($sformatf("tbl%0d_wdata", i), sWd, tbl[i].eWd);
            chk($sformatf("tbl%0d_ReadDataW", i), ReadDataW, tbl[i].eRd);
            chk($sformatf("tbl%0d_RegWriteW", i), 32'(RegWriteW), 32'(tbl[i].eRw));
            chk($sformatf("tbl%0d_ExcW", i), 32'(ExcW), 32'd0);
        end

        // SH ready after 3 cycles: 3 stall cycles, 3 bubbles.
        setOp(0, 0, 3'd0, 1, 32'h0, 32'h0);
        tick();
        setOp(0, 1, 3'd1, 1, 32'h202, 32'h1234_ABCD);
        dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("sh_stall%0d", i), 32'(sStall), 32'd1);
            chk($sformatf("sh_be%0d", i), 32'(sBe), 32'b1100);
            chk($sformatf("sh_wdata%0d", i), sWd, 32'hABCD_ABCD);
            chk($sformatf("sh_bubble%0d", i), 32'(RegWriteW), 32'd0);
        end
        dmem_ready = 1;
        tick();
        chk("sh_done_stall", 32'(sStall), 32'd0);
        chk("sh_done_RegWriteW", 32'(RegWriteW), 32'd1);
        chk("sh_done_ReadDataW", ReadDataW, 32'd0);

        // Timeout abort.
        runHang("hang");

        // Reset in the middle of a WAIT, then a full timeout again.
        setOp(0, 0, 3'd0, 1, 32'h1234, 32'h0);
        tick();
        setOp(1, 0, 3'd2, 1, 32'h500, 32'h0);
        dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("pre_rst_stall%0d", i), 32'(sStall), 32'd1);
        end
        rst = 1;
        tick();
        chk("mid_rst_req", 32'(sReq), 32'd0);
        chk("mid_rst_stall", 32'(sStall), 32'd0);
        chk("mid_rst_PCPlus4W", PCPlus4W, 32'd0);
        chk("mid_rst_InstrW", InstrW, 32'd0);
        chk("mid_rst_ALU_ResultW", ALU_ResultW, 32'd0);
        rst = 0;
        runHang("postrst");

        // Misaligned word load.
        setOp(1, 0, 3'd2, 1, 32'h301, 32'h0);
        dmem_ready = 1;
        dmem_rdata = 32'h5555_AAAA;
        tick();
`ifdef MISALIGN_CHECK_EN
        chk("mis_req", 32'(sReq), 32'd0);
        chk("mis_ExcW", 32'(ExcW), 32'd1);
        chk("mis_RegWriteW", 32'(RegWriteW), 32'd0);
`else
        chk("mis_req", 32'(sReq), 32'd1);
        chk("mis_addr", sAddr, 32'h300);
        chk("mis_be", 32'(sBe), 32'b1111);
        chk("mis_ExcW", 32'(ExcW), 32'd0);
`endif

        // Random traffic against the model.
        hang = 0;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 60) == 0);
            if (!mStall) begin
                kind        = int'($urandom_range(0, 2));
                LoadM       = (kind == 1);
                StoreM      = (kind == 2);
                RegWriteM   = 1'($urandom);
                ResultSrcM  = 2'($urandom);
                RD_M        = 5'($urandom);
                PCPlus4M    = $urandom;
                WriteDataM  = $urandom;
                ALU_ResultM = $urandom;
                InstrM      = $urandom;
                hang        = ($urandom_range(0, 7) == 0);
            end
            dmem_ready = hang ? 1'b0 : ($urandom_range(0, 2) != 0);
            dmem_rdata = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_cycle.md
MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15, the maximum data-memory wait cycles before an access is aborted (range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port RegWriteM  input  1  register-write enable from the execute stage.
REQ-005 SHALL have port ResultSrcM  input  2  writeback result select.
REQ-006 SHALL have port LoadM  input  1  instruction is a load.
REQ-007 SHALL have port StoreM  input  1  instruction is a store.
REQ-008 SHALL have port RD_M  input  5  destination register.
REQ-009 SHALL have port PCPlus4M  input  32  PC+4 of the instruction.
REQ-010 SHALL have port WriteDataM  input  32  store data.
REQ-011 SHALL have port ALU_ResultM  input  32  effective address / ALU result.
REQ-012 SHALL have port InstrM  input  32  instruction word; funct3 = InstrM[14:12].
REQ-013 SHALL have port dmem_req  output  1  access request.
REQ-014 SHALL have port dmem_we  output  1  1 = write.
REQ-015 SHALL have port dmem_addr  output  32  word address {ALU_ResultM[31:2],2'b00}.
REQ-016 SHALL have port dmem_wdata  output  32  lane-replicated store data.
REQ-017 SHALL have port dmem_be  output  4  byte enables.
REQ-018 SHALL have port dmem_ready  input  1  access completes this cycle.
REQ-019 SHALL have port dmem_rdata  input  32  read word, valid when dmem_ready=1.
REQ-020 SHALL have port StallM  output  1  freeze fetch/decode/execute and the M register.
REQ-021 SHALL have registered outputs RegWriteW(1), ResultSrcW(2), RD_W(5), PCPlus4W(32), ALU_ResultW(32), InstrW(32) to the writeback stage.
REQ-022 SHALL have port ReadDataW  output  32  extended load data, registered.
REQ-023 SHALL have port ExcW  output  1  access fault flag accompanying the instruction, registered.

Function
REQ-024 Access = LoadM|StoreM. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW. Any other funct3 on an access SHALL be treated as a word access.
REQ-025 Byte enables: SB 4'b0001<<a[1:0]. SH 4'b0011<<{a[1],1'b0}. SW 4'b1111, where a = ALU_ResultM. dmem_wdata: byte replicated x4, half x2, word as-is. dmem_we = StoreM.
REQ-026 FSM states IDLE and WAIT. In IDLE, an access asserts dmem_req combinationally. dmem_ready=1 completes the access that cycle and stays IDLE. Otherwise next state is WAIT.
REQ-027 In WAIT, dmem_req=1 with address, data and enables stable. dmem_ready=1 completes the access and returns to IDLE.
REQ-028 Wait counter (8 bits): cleared in IDLE, incremented each WAIT cycle without ready. When the counter reaches WAIT_MAX the access aborts: return to IDLE, dmem_req=0 next cycle, ExcW=1 and RegWriteW=0 for that instruction. Ready in the limit cycle SHALL take precedence over abort.
REQ-029 StallM = access & ~dmem_ready & ~abort. While StallM=1, the W register SHALL load a bubble: RegWriteW=0, ExcW=0, other W outputs hold.
REQ-030 Non-access instruction: no request, StallM=0, W outputs updated next edge (1-cycle latency), ReadDataW=0.
REQ-031 Load completion: ReadDataW = lane selected by a[1:0] (byte) or a[1] (half), sign-extended for LB/LH, zero-extended for LBU/LHU, full word for LW.
REQ-032 Stores SHALL pass RegWriteM unchanged. ReadDataW=0 on stores.

Reset
REQ-033 rst=1 at a clock edge: state IDLE, counter 0, all W outputs 0. While rst=1, dmem_req=0 and StallM=0 regardless of inputs, including an abandoned WAIT.

Configuration
REQ-034 MISALIGN_CHECK_EN defined: an LH/LHU/SH with a[0]=1 or an LW/SW with a[1:0]!=0 SHALL NOT be issued (dmem_req=0). It completes in 1 cycle with ExcW=1, RegWriteW=0. Undefined: no check; halfword uses a[1] only, word ignores a[1:0]; ExcW arises only from timeout.

Verification
REQ-035 LB, a=0x103, rdata=0x80FF_0000, ready same cycle -> dmem_be=0001, no stall, ReadDataW=0xFFFF_FF80, RegWriteW=1.
REQ-036 SH, a=0x202, WriteDataM=0x1234_ABCD, ready after 3 cycles -> dmem_be=1100, wdata=0xABCD_ABCD, StallM=1 for 3 cycles, 3 bubbles.
REQ-037 LW, ready never, WAIT_MAX=4 -> dmem_req drops after 4 WAIT cycles, ExcW=1, RegWriteW=0, StallM released.
REQ-038 LW in WAIT, rst pulsed 1 cycle -> dmem_req=0 and StallM=0 next cycle, all W outputs 0, state IDLE.
REQ-039 LW a=0x301 -> with MISALIGN_CHECK_EN: no request, ExcW=1. Without it: dmem_addr=0x300, be=1111, ExcW=0.
